// File: rtl/alu_exec_pkg.sv
// Shared definitions for the ALU execute-stage sequencer.
//   - ALU mode encodings (instr[7:4])
//   - sequencer state type
//   - status flag bit positions {Z,C,S,O}
//   - predicates classifying modes for the flag update rule
package alu_exec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  localparam logic [3:0] MODE_ADD   = 4'b0000;
  localparam logic [3:0] MODE_SUBAM = 4'b0001;
  localparam logic [3:0] MODE_MOVAM = 4'b0010;
  localparam logic [3:0] MODE_MOVMA = 4'b0011;
  localparam logic [3:0] MODE_AND   = 4'b0100;
  localparam logic [3:0] MODE_OR    = 4'b0101;
  localparam logic [3:0] MODE_XOR   = 4'b0110;
  localparam logic [3:0] MODE_SUBMA = 4'b0111;
  localparam logic [3:0] MODE_INCA  = 4'b1000;
  localparam logic [3:0] MODE_DECA  = 4'b1001;
  localparam logic [3:0] MODE_CMPL  = 4'b1111;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_S = 1;
  localparam int FLAG_O = 0;

  // Modes whose ALU carry output is meaningful.
  function automatic logic is_carry_mode(input logic [3:0] mode);
    return (mode == MODE_ADD)  || (mode == MODE_SUBAM) || (mode == MODE_SUBMA) ||
           (mode == MODE_INCA) || (mode == MODE_DECA)  || (mode == MODE_CMPL);
  endfunction

  // Pure data moves never touch the status register.
  function automatic logic is_mov_mode(input logic [3:0] mode);
    return (mode == MODE_MOVAM) || (mode == MODE_MOVMA);
  endfunction

endpackage

// File: rtl/alu_flag_merge.sv
// Next status register value for a retiring instruction.
// Ports:
//   mode       in  4  ALU mode of the instruction
//   alu_flags  in  4  flags produced by the ALU {Z,C,S,O}
//   flags      in  4  current status register
//   next_flags out 4  value to commit
module alu_flag_merge
  import alu_exec_pkg::*;
(
  input  logic [3:0] mode,
  input  logic [3:0] alu_flags,
  input  logic [3:0] flags,
  output logic [3:0] next_flags
);

  always_comb begin
    next_flags = alu_flags;
    if (is_mov_mode(mode)) begin
      next_flags = flags;
    end else if (!is_carry_mode(mode)) begin
      // ALU carry is undefined for these modes; keep the architectural C.
      next_flags[FLAG_C] = flags[FLAG_C];
    end
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer: IDLE -> EXEC -> WB -> IDLE.
// Accepts an instruction byte with its memory operand, presents operands to
// the external combinational ALU for one cycle, then commits the result to
// the accumulator (or to memory for MOVAM) and updates {Z,C,S,O}.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   instr_valid/instr_ready  instruction handshake (ready only in IDLE)
//   instr, mem_operand       instruction byte (mode = [7:4]) and operand M
//   alu_op1/op2/en/mode/cflags  drive to ALU; alu_out/alu_flags back
//   acc, flags               architectural accumulator and status register
//   mem_we/mem_wdata/wb_ready   memory write for MOVAM, held until accepted
//   done                     one-cycle retire pulse
//   instr_count              retired count (only with ALU_PERF_CNT_EN, else 0)
// Build option: ALU_PERF_CNT_EN enables the saturating retire counter.
module alu_exec_ctrl
  import alu_exec_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] ACC_RST   = 8'h00,
  parameter logic [3:0]        FLAGS_RST = 4'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [7:0]        instr,
  input  logic [DATA_W-1:0] mem_operand,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic              alu_en,
  output logic [3:0]        alu_mode,
  output logic [3:0]        alu_cflags,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [3:0]        alu_flags,
  output logic [DATA_W-1:0] acc,
  output logic [3:0]        flags,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              wb_ready,
  output logic              done,
  output logic [15:0]       instr_count
);

  state_t            state;
  logic [3:0]        mode_q;
  logic [DATA_W-1:0] m_q;
  logic [DATA_W-1:0] acc_q;
  logic [3:0]        flags_q;
  logic [DATA_W-1:0] result_q;
  logic              mem_we_q;
  logic [3:0]        next_flags;
  logic              wb_done;

  // Low nibble of the instruction carries no meaning for this stage.
  logic unused_instr;
  assign unused_instr = ^instr[3:0];

  alu_flag_merge u_flag_merge (
    .mode       (mode_q),
    .alu_flags  (alu_flags),
    .flags      (flags_q),
    .next_flags (next_flags)
  );

  // Non-MOVAM writeback lasts one cycle; MOVAM waits for the memory.
  assign wb_done = (state == ST_WB) && (!mem_we_q || wb_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      mode_q   <= '0;
      m_q      <= '0;
      acc_q    <= ACC_RST;
      flags_q  <= FLAGS_RST;
      result_q <= '0;
      mem_we_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            mode_q <= instr[7:4];
            m_q    <= mem_operand;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // ALU is combinational: its outputs are valid within this cycle,
          // so the commit happens on the edge that enters WB.
          result_q <= alu_out;
          if (mode_q == MODE_MOVAM) begin
            mem_we_q <= 1'b1;
          end else begin
            acc_q   <= alu_out;
            flags_q <= next_flags;
          end
          state <= ST_WB;
        end
        ST_WB: begin
          if (wb_done) begin
            mem_we_q <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_PERF_CNT_EN
  logic [15:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          cnt_q <= '0;
    else if (wb_done && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  end
  assign instr_count = cnt_q;
`else
  assign instr_count = 16'h0000;
`endif

  assign instr_ready = (state == ST_IDLE);
  assign alu_en      = (state == ST_EXEC);
  assign alu_op1     = acc_q;
  assign alu_op2     = m_q;
  assign alu_mode    = mode_q;
  assign alu_cflags  = flags_q;
  assign acc         = acc_q;
  assign flags       = flags_q;
  assign mem_we      = mem_we_q;
  assign mem_wdata   = result_q;
  assign done        = wb_done;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a small behavioural ALU model.
module tb_alu_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr;
  logic [7:0]  mem_operand;
  logic [7:0]  alu_op1, alu_op2;
  logic        alu_en;
  logic [3:0]  alu_mode;
  logic [3:0]  alu_cflags;
  logic [7:0]  alu_out;
  logic [3:0]  alu_flags;
  logic [7:0]  acc;
  logic [3:0]  flags;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic        wb_ready;
  logic        done;
  logic [15:0] instr_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_exec_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .mem_operand(mem_operand), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_en(alu_en), .alu_mode(alu_mode), .alu_cflags(alu_cflags), .alu_out(alu_out),
    .alu_flags(alu_flags), .acc(acc), .flags(flags), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .wb_ready(wb_ready), .done(done), .instr_count(instr_count)
  );

  // Behavioural ALU: flags {Z,C,S,O}. Moves report all-ones flags and
  // non-carry modes report C=0 so the sequencer's masking is observable.
  always_comb begin
    logic [8:0] s;
    s = 9'd0;
    alu_out = alu_op1;
    alu_flags = 4'b0000;
    case (alu_mode)
      4'h0: begin
        s = {1'b0, alu_op1} + {1'b0, alu_op2};
        alu_out = s[7:0];
        alu_flags[2] = s[8];
        alu_flags[0] = (alu_op1[7] == alu_op2[7]) && (s[7] != alu_op1[7]);
      end
      4'h1: begin
        alu_out = alu_op1 - alu_op2;
        alu_flags[2] = ~alu_out[7];
        alu_flags[0] = (alu_op1[7] != alu_op2[7]) && (alu_out[7] != alu_op1[7]);
      end
      4'h2: alu_out = alu_op1;
      4'h3: alu_out = alu_op2;
      4'h4: alu_out = alu_op1 & alu_op2;
      4'h5: alu_out = alu_op1 | alu_op2;
      4'h6: alu_out = alu_op1 ^ alu_op2;
      4'h8: begin
        s = {1'b0, alu_op1} + 9'd1;
        alu_out = s[7:0];
        alu_flags[2] = s[8];
        alu_flags[0] = (alu_op1 == 8'h7F);
      end
      4'hF: begin
        alu_out = ~alu_op1;
        alu_flags[2] = 1'b1;
      end
      default: alu_out = alu_op1;
    endcase
    if (alu_mode != 4'h2 && alu_mode != 4'h3) begin
      alu_flags[3] = (alu_out == 8'h00);
      alu_flags[1] = alu_out[7];
    end else begin
      alu_flags = 4'b1111;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Non-MOVAM instruction: drive at negedge, accept on next posedge,
  // EXEC and WB cycles checked at their negedges.
  task automatic run_instr(input logic [7:0] i, input logic [7:0] m);
    @(negedge clk);
    chk("ready_idle", {15'd0, instr_ready}, 16'd1);
    instr_valid = 1'b1; instr = i; mem_operand = m;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("exec_en", {15'd0, alu_en}, 16'd1);
    chk("exec_mode", {12'd0, alu_mode}, {12'd0, i[7:4]});
    chk("exec_op2", {8'd0, alu_op2}, {8'd0, m});
    chk("exec_nodone", {14'd0, done, instr_ready}, 16'd0);
    @(negedge clk);
    chk("wb_done", {14'd0, done, mem_we}, 16'b10);
    chk("wb_en", {15'd0, alu_en}, 16'd0);
  endtask

  typedef struct {
    logic [7:0] instr;
    logic [7:0] m;
    logic [7:0] exp_acc;
    logic [3:0] exp_flags;
  } vec_t;

  vec_t vecs[14];
  int accepts, dones;
  logic [15:0] exp_cnt;

  initial begin
    // Cumulative program: each row starts from the previous row's acc/flags.
    vecs[0]  = '{8'h30, 8'h05, 8'h05, 4'b0000};  // MOVMA load
    vecs[1]  = '{8'h00, 8'h03, 8'h08, 4'b0000};  // ADD 05+03
    vecs[2]  = '{8'h30, 8'h03, 8'h03, 4'b0000};  // MOVMA, flags kept
    vecs[3]  = '{8'h10, 8'h05, 8'hFE, 4'b0010};  // SUBAM 03-05
    vecs[4]  = '{8'h30, 8'hFF, 8'hFF, 4'b0010};
    vecs[5]  = '{8'h00, 8'h02, 8'h01, 4'b0100};  // ADD carry out
    vecs[6]  = '{8'h30, 8'hF0, 8'hF0, 4'b0100};
    vecs[7]  = '{8'h40, 8'h0F, 8'h00, 4'b1100};  // AND keeps C
    vecs[8]  = '{8'h5A, 8'h80, 8'h80, 4'b0110};  // OR, low nibble ignored
    vecs[9]  = '{8'h60, 8'h80, 8'h00, 4'b1100};  // XOR keeps C
    vecs[10] = '{8'h80, 8'h00, 8'h01, 4'b0000};  // INCA takes C=0
    vecs[11] = '{8'h00, 8'h7F, 8'h80, 4'b0011};  // ADD signed overflow
    vecs[12] = '{8'hF0, 8'h00, 8'h7F, 4'b0100};  // CMPL takes C=1
    vecs[13] = '{8'hA0, 8'h33, 8'h7F, 4'b0100};  // non-carry mode keeps C

    rst_n = 1'b0; instr_valid = 1'b0; instr = 8'h00; mem_operand = 8'h00; wb_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_acc", {8'd0, acc}, 16'h0000);
    chk("rst_flags", {12'd0, flags}, 16'h0000);
    chk("rst_ctl", {11'd0, instr_ready, done, alu_en, mem_we, 1'b0}, 16'b10000);
    chk("rst_ops", {alu_op1, alu_op2}, 16'h0000);
    chk("rst_cnt", instr_count, 16'h0000);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      run_instr(vecs[k].instr, vecs[k].m);
      chk($sformatf("vec%0d_acc", k), {8'd0, acc}, {8'd0, vecs[k].exp_acc});
      chk($sformatf("vec%0d_flags", k), {12'd0, flags}, {12'd0, vecs[k].exp_flags});
      chk($sformatf("vec%0d_cflags", k), {12'd0, alu_cflags}, {12'd0, vecs[k].exp_flags});
    end

    // MOVAM with memory stall: wb_ready low for 3 WB cycles, high on the 4th.
    run_instr(8'h30, 8'h5A);
    @(negedge clk);
    instr_valid = 1'b1; instr = 8'h20; mem_operand = 8'h11;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("movam_exec", {14'd0, mem_we, done}, 16'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 3) wb_ready = 1'b1;
      #1;
      chk($sformatf("movam_we%0d", c), {7'd0, mem_we, mem_wdata}, {7'd0, 1'b1, 8'h5A});
      chk($sformatf("movam_done%0d", c), {14'd0, done, instr_ready}, {14'd0, (c == 3), 1'b0});
    end
    @(negedge clk);
    wb_ready = 1'b0;
    chk("movam_after", {13'd0, done, mem_we, instr_ready}, 16'b001);
    chk("movam_acc", {4'd0, flags, acc}, {4'd0, 4'b0100, 8'h5A});

    // Asynchronous reset during EXEC aborts the instruction.
    run_instr(8'h30, 8'h11);
    @(negedge clk);
    instr_valid = 1'b1; instr = 8'h00; mem_operand = 8'h01;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("rexec_en", {15'd0, alu_en}, 16'd1);
    rst_n = 1'b0;
    #1;
    chk("rexec_state", {8'd0, acc}, 16'h0000);
    chk("rexec_flags", {12'd0, flags}, 16'h0000);
    chk("rexec_ctl", {13'd0, done, alu_en, mem_we}, 16'd0);
    @(negedge clk);
    chk("rexec_hold", {14'd0, done, instr_ready}, 16'b01);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rexec_idle", {7'd0, instr_ready, acc}, {7'd0, 1'b1, 8'h00});

    // Back-to-back: valid held high for three ADD #1.
    accepts = 0; dones = 0;
    instr_valid = 1'b1; instr = 8'h00; mem_operand = 8'h01;
    for (int c = 0; c < 9; c++) begin
      if (instr_ready) begin
        accepts++;
        chk($sformatf("b2b_slot%0d", c), c % 3, 0);
      end
      if (done) dones++;
      if (c == 8) instr_valid = 1'b0;
      @(negedge clk);
    end
    chk("b2b_accepts", accepts[15:0], 16'd3);
    chk("b2b_dones", dones[15:0], 16'd3);
    chk("b2b_acc", {8'd0, acc}, 16'h0003);
`ifdef ALU_PERF_CNT_EN
    exp_cnt = 16'd3;
`else
    exp_cnt = 16'd0;
`endif
    chk("b2b_cnt", instr_count, exp_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
